// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: Moore control unit for the multicycle datapath.
module multicycle_control_fsm #(
  parameter bit ENABLE_STALL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       Zero,
  input  logic       MemReady,
  output logic [1:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       IorD,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       PCEn,
  output logic       InstrDone,
  output logic       IllegalOp,
  output logic [3:0] State
);
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RT   = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  state_t state_q, state_d;
  logic   rdy, legal;
  assign rdy   = MemReady | ~ENABLE_STALL;
  assign legal = Op inside {OP_LW, OP_SW, OP_RT, OP_BEQ, OP_ADDI, OP_J};
  assign State = state_q;
  always_ff @(posedge clk)
    state_q <= reset ? FETCH : state_d;
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = rdy ? DECODE : FETCH;
      DECODE: state_d = (Op == OP_LW || Op == OP_SW) ? MEMADR :
                        (Op == OP_RT)   ? EXEC   :
                        (Op == OP_BEQ)  ? BRANCH :
                        (Op == OP_ADDI) ? ADDIEX :
                        (Op == OP_J)    ? JUMP   : FETCH;
      MEMADR: state_d = (Op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  state_d = rdy ? MEMWB : MEMRD;
      MEMWR:  state_d = rdy ? FETCH : MEMWR;
      EXEC:   state_d = ALUWB;
      ADDIEX: state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end
  // Selects follow State alone; enables and pulses are additionally gated off by reset.
  always_comb begin
    ALUOp     = (state_q == EXEC) ? 2'b10 : (state_q == BRANCH) ? 2'b01 : 2'b00;
    ALUSrcA   = state_q inside {MEMADR, EXEC, BRANCH, ADDIEX};
    ALUSrcB   = (state_q == FETCH)  ? 2'b01 :
                (state_q == DECODE) ? 2'b11 :
                (state_q inside {MEMADR, ADDIEX}) ? 2'b10 : 2'b00;
    PCSrc     = (state_q == BRANCH) ? 2'b01 : (state_q == JUMP) ? 2'b10 : 2'b00;
    IorD      = state_q inside {MEMRD, MEMWR};
    RegDst    = state_q == ALUWB;
    MemtoReg  = state_q == MEMWB;
    IRWrite   = !reset && state_q == FETCH && rdy;
    MemWrite  = !reset && state_q == MEMWR;
    RegWrite  = !reset && state_q inside {MEMWB, ALUWB, ADDIWB};
    PCEn      = !reset && ((state_q == FETCH && rdy) || (state_q == BRANCH && Zero) ||
                           state_q == JUMP);
    IllegalOp = !reset && state_q == DECODE && !legal;
    InstrDone = !reset && (state_q inside {MEMWB, ALUWB, BRANCH, ADDIWB, JUMP} ||
                           (state_q == MEMWR && rdy) || (state_q == DECODE && !legal));
  end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: scoreboard bench for the multicycle control FSM.
module tb_multicycle_control_fsm;
  localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MR = 4'd3, WB = 4'd4, MW = 4'd5,
                         EX = 4'd6, AW = 4'd7, BR = 4'd8, IE = 4'd9, IW = 4'd10, JP = 4'd11,
                         SKIP = 4'd15;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] Op = RT;
  logic Zero = 1'b0;
  logic MemReady = 1'b1;
  logic [1:0] aop_a, srcb_a, pcs_a, aop_b, srcb_b, pcs_b;
  logic srca_a, iord_a, rd_a, m2r_a, irw_a, mw_a, rw_a, pe_a, dn_a, il_a;
  logic srca_b, iord_b, rd_b, m2r_b, irw_b, mw_b, rw_b, pe_b, dn_b, il_b;
  logic [3:0] st_a, st_b;
  logic [15:0] o_a, o_b;
  int n_run = 0;
  int n_fail = 0;
  logic [3:0]  q_st[$];
  logic [15:0] q_o[$];
  string       q_tag[$];
  always #5 clk = ~clk;
  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .MemReady(MemReady),
    .ALUOp(aop_a), .ALUSrcA(srca_a), .ALUSrcB(srcb_a), .PCSrc(pcs_a), .IorD(iord_a),
    .RegDst(rd_a), .MemtoReg(m2r_a), .IRWrite(irw_a), .MemWrite(mw_a), .RegWrite(rw_a),
    .PCEn(pe_a), .InstrDone(dn_a), .IllegalOp(il_a), .State(st_a)
  );
  multicycle_control_fsm #(.ENABLE_STALL(1'b0)) dut_ns (
    .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .MemReady(MemReady),
    .ALUOp(aop_b), .ALUSrcA(srca_b), .ALUSrcB(srcb_b), .PCSrc(pcs_b), .IorD(iord_b),
    .RegDst(rd_b), .MemtoReg(m2r_b), .IRWrite(irw_b), .MemWrite(mw_b), .RegWrite(rw_b),
    .PCEn(pe_b), .InstrDone(dn_b), .IllegalOp(il_b), .State(st_b)
  );
  assign o_a = {aop_a, srca_a, srcb_a, pcs_a, iord_a, rd_a, m2r_a, irw_a, mw_a, rw_a, pe_a, dn_a, il_a};
  assign o_b = {aop_b, srca_b, srcb_b, pcs_b, iord_b, rd_b, m2r_b, irw_b, mw_b, rw_b, pe_b, dn_b, il_b};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Expected output vector for a state, built from the per-state output table.
  function automatic logic [15:0] exp_o(input logic [3:0] st, input logic rdy, input logic z,
                                        input logic [5:0] op, input logic r);
    logic [1:0] aop, sb, pc;
    logic sa, iord, rd, m2r, irw, mw, rw, pe, dn, il;
    {aop, sa, sb, pc, iord, rd, m2r, irw, mw, rw, pe, dn, il} = '0;
    case (st)
      F:  begin sb = 2'b01; irw = rdy; pe = rdy; end
      D:  begin sb = 2'b11; il = !(op inside {LW, SW, RT, BEQ, ADDI, J}); dn = il; end
      MA: begin sa = 1'b1; sb = 2'b10; end
      MR: iord = 1'b1;
      WB: begin m2r = 1'b1; rw = 1'b1; dn = 1'b1; end
      MW: begin iord = 1'b1; mw = 1'b1; dn = rdy; end
      EX: begin sa = 1'b1; aop = 2'b10; end
      AW: begin rd = 1'b1; rw = 1'b1; dn = 1'b1; end
      BR: begin sa = 1'b1; aop = 2'b01; pc = 2'b01; pe = z; dn = 1'b1; end
      IE: begin sa = 1'b1; sb = 2'b10; end
      IW: begin rw = 1'b1; dn = 1'b1; end
      JP: begin pc = 2'b10; pe = 1'b1; dn = 1'b1; end
      default: ;
    endcase
    if (r) {irw, mw, rw, pe, dn, il} = '0;
    return {aop, sa, sb, pc, iord, rd, m2r, irw, mw, rw, pe, dn, il};
  endfunction
  // One cycle: drive inputs, queue the expected state/outputs of the stalling instance.
  task automatic cyc(input logic r, input logic mr, input logic z, input logic [5:0] op,
                     input logic [3:0] st, input logic [3:0] ns_st, input string tag);
    @(negedge clk);
    reset = r; MemReady = mr; Zero = z; Op = op;
    q_st.push_back(st);
    q_o.push_back(exp_o(st, mr, z, op, r));
    q_tag.push_back(tag);
    if (ns_st != SKIP) begin
      #2;
      chk({tag, "/ns_state"}, 32'(st_b), 32'(ns_st));
      chk({tag, "/ns_outs"}, 32'(o_b), 32'(exp_o(ns_st, 1'b1, z, op, r)));
    end
  endtask
  always @(negedge clk) begin
    #2;
    if (q_st.size() > 0) begin
      automatic logic [3:0]  es = q_st.pop_front();
      automatic logic [15:0] eo = q_o.pop_front();
      automatic string       t  = q_tag.pop_front();
      chk({t, "/state"}, 32'(st_a), 32'(es));
      chk({t, "/outs"}, 32'(o_a), 32'(eo));
    end
  end
  initial begin
    cyc(1, 1, 0, RT, F, SKIP, "rst");
    cyc(0, 1, 0, RT, F, SKIP, "rt_fetch");
    cyc(0, 1, 1, RT, D, SKIP, "rt_dec");
    cyc(0, 1, 0, LW, EX, SKIP, "rt_exec");
    cyc(0, 1, 0, SW, AW, SKIP, "rt_wb");
    cyc(0, 0, 0, LW, F, SKIP, "lw_f_stall1");
    cyc(0, 0, 0, LW, F, SKIP, "lw_f_stall2");
    cyc(0, 1, 0, LW, F, SKIP, "lw_fetch");
    cyc(0, 1, 0, LW, D, SKIP, "lw_dec");
    cyc(0, 1, 0, LW, MA, SKIP, "lw_adr");
    cyc(0, 0, 0, RT, MR, SKIP, "lw_rd_stall1");
    cyc(0, 0, 0, SW, MR, SKIP, "lw_rd_stall2");
    cyc(0, 0, 1, LW, MR, SKIP, "lw_rd_stall3");
    cyc(0, 1, 0, LW, MR, SKIP, "lw_rd");
    cyc(0, 1, 0, LW, WB, SKIP, "lw_wb");
    cyc(0, 1, 0, SW, F, SKIP, "sw_fetch");
    cyc(0, 1, 0, SW, D, SKIP, "sw_dec");
    cyc(0, 1, 0, SW, MA, SKIP, "sw_adr");
    cyc(0, 0, 0, RT, MW, SKIP, "sw_wr_stall");
    cyc(0, 1, 0, RT, MW, SKIP, "sw_wr");
    cyc(0, 1, 1, BEQ, F, SKIP, "beq1_fetch");
    cyc(0, 1, 1, BEQ, D, SKIP, "beq1_dec");
    cyc(0, 1, 1, BEQ, BR, SKIP, "beq1_br");
    cyc(0, 1, 0, BEQ, F, SKIP, "beq0_fetch");
    cyc(0, 1, 0, BEQ, D, SKIP, "beq0_dec");
    cyc(0, 1, 0, BEQ, BR, SKIP, "beq0_br");
    cyc(0, 1, 0, J, F, SKIP, "j_fetch");
    cyc(0, 1, 0, J, D, SKIP, "j_dec");
    cyc(0, 1, 0, J, JP, SKIP, "j_jump");
    cyc(0, 1, 0, BAD, F, SKIP, "ill_fetch");
    cyc(0, 1, 0, BAD, D, SKIP, "ill_dec");
    cyc(0, 1, 0, ADDI, F, SKIP, "addi_fetch");
    cyc(0, 1, 0, ADDI, D, SKIP, "addi_dec");
    cyc(0, 1, 0, ADDI, IE, SKIP, "addi_ex");
    cyc(0, 1, 0, ADDI, IW, SKIP, "addi_wb");
    cyc(0, 1, 0, LW, F, SKIP, "rlw_fetch");
    cyc(0, 1, 0, LW, D, SKIP, "rlw_dec");
    cyc(0, 1, 0, LW, MA, SKIP, "rlw_adr");
    cyc(0, 0, 0, LW, MR, SKIP, "rlw_stall");
    cyc(1, 0, 0, LW, MR, SKIP, "rlw_reset");
    cyc(0, 1, 0, LW, F, SKIP, "rlw_after");
    cyc(1, 0, 0, LW, D, SKIP, "ns_reset");
    cyc(0, 0, 0, LW, F, F, "ns_c1");
    cyc(0, 0, 0, LW, F, D, "ns_c2");
    cyc(0, 0, 0, LW, F, MA, "ns_c3");
    cyc(0, 0, 0, LW, F, MR, "ns_c4");
    cyc(0, 0, 0, LW, F, WB, "ns_c5");
    cyc(0, 0, 0, LW, F, F, "ns_done");
    @(negedge clk);
    #3;
    chk("drain", 32'(q_st.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main control unit for the multicycle datapath variant of the processor.
- Decodes the instruction opcode with a Moore state machine and drives every datapath mux select and write enable.
- Produces the 2-bit ALUOp consumed directly by the downstream ALU decoder (00 add, 01 sub, 10 use Funct).
- Stalls on a memory-ready handshake for instruction fetch, data load and data store.

Parameters:
- ENABLE_STALL, 1: when 0, MemReady is ignored and treated as constant 1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- Op  in  6  instruction opcode, Instr[31:26], valid from DECODE onward.
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory completes the current access this cycle.
- ALUOp  out  2  to ALU decoder.
- ALUSrcA  out  1  0=PC, 1=A register.
- ALUSrcB  out  2  00=B, 01=const 4, 10=SignImm, 11=SignImm<<2.
- PCSrc  out  2  00=ALUResult, 01=ALUOut, 10=jump target.
- IorD, RegDst, MemtoReg  out  1 each  datapath selects.
- IRWrite, MemWrite, RegWrite, PCEn  out  1 each  write enables.
- InstrDone  out  1  one-cycle pulse in the final state of each instruction.
- IllegalOp  out  1  high in DECODE when Op is unsupported.
- State  out  4  current state, for debug.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. A clk edge with reset=1 loads FETCH.
- Outputs while reset=1: IRWrite, MemWrite, RegWrite, PCEn, InstrDone and IllegalOp are all forced to 0.
- Output decode: outputs are pure combinational functions of State (Moore), plus MemReady, Zero and Op where noted below. Every output not listed for a state is 0.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
- Encodings 12-15 drive all outputs to 0 and go to FETCH on the next edge.
- Stall qualifier: rdy = MemReady | ~ENABLE_STALL.
- FETCH: ALUSrcB=01, ALUOp=00, IorD=0, IRWrite=rdy, PCEn=rdy. Stay while !rdy; go to DECODE when rdy.
- DECODE: ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by Op:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 (R-type) -> EXEC
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JUMP
  - any other Op -> IllegalOp=1, InstrDone=1, next FETCH (executes as NOP).
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: IorD=1. Stay while !rdy; go to MEMWB when rdy.
- MEMWB: MemtoReg=1, RegDst=0, RegWrite=1, InstrDone=1. Next FETCH.
- MEMWR: IorD=1, MemWrite=1, held for the whole stall. When rdy, InstrDone=1 and next FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, InstrDone=1. Next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, PCEn=Zero, InstrDone=1. Next FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, InstrDone=1. Next FETCH.
- JUMP: PCSrc=10, PCEn=1, InstrDone=1. Next FETCH.
- Op sampling: Op is sampled only in DECODE (dispatch) and MEMADR (lw/sw split). Op changes in other states have no effect.
- Reset mid-instruction, including during a stall: the next edge goes to FETCH. No write enable is asserted in the reset cycle.
- Latency in cycles with no stalls: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Stall cost: each !rdy cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.

Test Plan:
- Reset, then R-type: reset=1 for 2 cycles with MemReady=1, Op=000000 -> State sequence 0,1,6,7,0. ALUOp=10 in EXEC. RegWrite=1 and RegDst=1 in ALUWB. InstrDone pulses once.
- lw with stalls: Op=100011, MemReady low for 2 cycles in FETCH and 3 cycles in MEMRD -> FETCH lasts 3 cycles and MEMRD lasts 4. IRWrite and PCEn are high only in the last FETCH cycle. RegWrite=1 with MemtoReg=1 in MEMWB. Total 10 cycles.
- sw: Op=101011, MemReady low 1 cycle in MEMWR -> MemWrite=1 for 2 consecutive cycles. RegWrite stays 0. Back to FETCH after 5 cycles.
- beq: Op=000100 with Zero=1 -> PCEn=1, PCSrc=01, ALUOp=01 in BRANCH. Repeat with Zero=0 -> PCEn=0.
- j and illegal: Op=000010 -> JUMP with PCSrc=10, PCEn=1. Op=111111 -> IllegalOp=1 in DECODE, then FETCH, with no writes asserted.
- Reset mid-op and ENABLE_STALL=0: assert reset while in MEMRD stalled -> State=0 next cycle with all enables 0 during reset. With ENABLE_STALL=0 and MemReady=0, lw completes in 5 cycles.
